// File: rtl/isp2wdma_pkg.sv
// isp2wdma_pkg: shared types and AHB encodings for the ISP write-DMA stage.
//   wdma_state_t : writer FSM states
//   HTRANS_* / HSIZE_* / HBURST_* / HRESP_* : AHB field encodings used by the writer
package isp2wdma_pkg;

   typedef enum logic [2:0] {
      WIDLE,
      WARM,
      WREQ,
      WADDR,
      WDATA,
      WDONE
   } wdma_state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [2:0] HSIZE_WORD    = 3'b010;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [1:0] HRESP_OKAY    = 2'b00;

endpackage

// File: rtl/isp2wdma_if.sv
// isp2wdma_if: AHB master-side bus of the write-DMA, including the arbiter handshake.
//   master modport : the DMA (drives address/control/data/request)
//   slave  modport : the bus fabric (drives ready/response/read data/grant)
interface isp2wdma_if;

   logic [31:0] dma_haddr;
   logic [1:0]  dma_htrans;
   logic        dma_hwrite;
   logic [2:0]  dma_hsize;
   logic [2:0]  dma_hburst;
   logic [3:0]  dma_hprot;
   logic [31:0] dma_hwdata;
   logic        dma_hbusreq;
   logic        dma_hlock;
   logic [31:0] hrdata_dma;
   logic        hready_dma;
   logic [1:0]  hresp_dma;
   logic        hgrant;

   modport master (
      output dma_haddr, dma_htrans, dma_hwrite, dma_hsize, dma_hburst, dma_hprot,
             dma_hwdata, dma_hbusreq, dma_hlock,
      input  hrdata_dma, hready_dma, hresp_dma, hgrant
   );

   modport slave (
      input  dma_haddr, dma_htrans, dma_hwrite, dma_hsize, dma_hburst, dma_hprot,
             dma_hwdata, dma_hbusreq, dma_hlock,
      output hrdata_dma, hready_dma, hresp_dma, hgrant
   );

endinterface

// File: rtl/isp2wdma_fifo.sv
// isp2wdma_fifo: synchronous 32-bit word FIFO, depth 2**AW, show-ahead head.
//   clk, rst    : clock, synchronous active-high reset
//   clr         : synchronous flush (frame start)
//   push, din   : write strobe/data; caller must not push when full without a pop
//   pop         : advance head; caller must not pop when empty
//   head        : current oldest word
//   full, empty : status
module isp2wdma_fifo #(
   parameter int AW = 11
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        push,
   input  logic [31:0] din,
   input  logic        pop,
   output logic [31:0] head,
   output logic        full,
   output logic        empty
);

   logic [31:0] mem [2**AW];
   logic [AW:0] wptr;
   logic [AW:0] rptr;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + (AW+1)'(1);
         if (pop)  rptr <= rptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= din;
   end

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/isp2wdma.sv
// isp2wdma: write-DMA stage behind the ISP. Captures out_raw pixels (one per word,
// zero-extended) into a word FIFO and writes them as AHB single-beat word writes.
//   hclk, hreset               : clock, synchronous active-high reset
//   isp_waddr/hsize/vsize      : frame base address and geometry (latched at start)
//   isp_start[0]               : start request (level)
//   isp_wdone                  : one-cycle completion/abort pulse
//   isp_werr, isp_wovf         : sticky error / overflow flags, cleared on start
//   bus                        : AHB master bus + arbiter handshake
//   out_href/out_vsync/out_raw : ISP pixel stream
module isp2wdma
   import isp2wdma_pkg::*;
#(
   parameter int BITS    = 8,
   parameter int FIFO_AW = 11
) (
   input  logic            hclk,
   input  logic            hreset,
   input  logic [31:0]     isp_waddr,
   input  logic [31:0]     isp_hsize,
   input  logic [31:0]     isp_vsize,
   input  logic [31:0]     isp_start,
   output logic            isp_wdone,
   output logic            isp_werr,
   output logic            isp_wovf,
   isp2wdma_if.master      bus,
   input  logic            out_href,
   input  logic            out_vsync,
   input  logic [BITS-1:0] out_raw
);

   wdma_state_t state;
   logic [31:0] cur_addr;
   logic [31:0] n_words;
   logic [31:0] cap_cnt;
   logic [31:0] wr_cnt;
   logic        cap_en;

   logic [31:0] pix_word;
   logic [31:0] fifo_head;
   logic        fifo_full;
   logic        fifo_empty;
   logic        cap_fire;
   logic        pop;
   logic        push;
   logic        drop;
   logic        start_ok;
   logic        unused_bits;

   assign unused_bits = ^{isp_start[31:1], bus.hrdata_dma};

   always_comb begin
      pix_word = '0;
      pix_word[BITS-1:0] = out_raw;
   end

   assign start_ok = (state == WIDLE) && isp_start[0] && !isp_wdone;
   assign cap_fire = cap_en && out_href && (cap_cnt < n_words);
   assign pop      = (state == WDATA) && bus.hready_dma;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign push     = cap_fire && (!fifo_full || pop);
   assign drop     = cap_fire && fifo_full && !pop;

   isp2wdma_fifo #(.AW(FIFO_AW)) u_fifo (
      .clk   (hclk),
      .rst   (hreset),
      .clr   (start_ok),
      .push  (push),
      .din   (pix_word),
      .pop   (pop),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign bus.dma_hburst = HBURST_SINGLE;
   assign bus.dma_hprot  = '0;
   assign bus.dma_hlock  = 1'b0;

   always_ff @(posedge hclk) begin
      if (hreset) begin
         state           <= WIDLE;
         cur_addr        <= '0;
         n_words         <= '0;
         cap_cnt         <= '0;
         wr_cnt          <= '0;
         cap_en          <= 1'b0;
         isp_wdone       <= 1'b0;
         isp_werr        <= 1'b0;
         isp_wovf        <= 1'b0;
         bus.dma_haddr   <= '0;
         bus.dma_htrans  <= HTRANS_IDLE;
         bus.dma_hwrite  <= 1'b0;
         bus.dma_hsize   <= '0;
         bus.dma_hwdata  <= '0;
         bus.dma_hbusreq <= 1'b0;
      end else begin
         isp_wdone <= 1'b0;
         if (cap_fire) cap_cnt  <= cap_cnt + 32'd1;
         if (drop)     isp_wovf <= 1'b1;

         unique case (state)
            WIDLE: begin
               if (start_ok) begin
                  cur_addr <= isp_waddr;
                  n_words  <= isp_hsize * isp_vsize;
                  cap_cnt  <= '0;
                  wr_cnt   <= '0;
                  isp_werr <= 1'b0;
                  isp_wovf <= 1'b0;
                  state    <= WARM;
               end
            end
            WARM: begin
               if (out_vsync) begin
                  cap_en          <= 1'b1;
                  bus.dma_hbusreq <= 1'b1;
                  state           <= WREQ;
               end
            end
            WREQ: begin
               // Dropped pixels never reach the FIFO, so finish once capture is
               // complete and everything captured has been written.
               if ((cap_cnt == n_words) && fifo_empty) begin
                  cap_en          <= 1'b0;
                  bus.dma_hbusreq <= 1'b0;
                  state           <= WDONE;
               end else if (bus.hgrant && bus.hready_dma && !fifo_empty) begin
                  bus.dma_haddr  <= cur_addr;
                  bus.dma_htrans <= HTRANS_NONSEQ;
                  bus.dma_hwrite <= 1'b1;
                  bus.dma_hsize  <= HSIZE_WORD;
                  state          <= WADDR;
               end
            end
            WADDR: begin
               if (bus.hready_dma) begin
                  bus.dma_haddr   <= '0;
                  bus.dma_htrans  <= HTRANS_IDLE;
                  bus.dma_hwrite  <= 1'b0;
                  bus.dma_hsize   <= '0;
                  bus.dma_hwdata  <= fifo_head;
                  bus.dma_hbusreq <= 1'b0;
                  state           <= WDATA;
               end
            end
            WDATA: begin
               if (bus.hready_dma) begin
                  cur_addr <= cur_addr + 32'd4;
                  wr_cnt   <= wr_cnt + 32'd1;
                  if (bus.hresp_dma != HRESP_OKAY) begin
                     isp_werr <= 1'b1;
                     cap_en   <= 1'b0;
                     state    <= WDONE;
                  end else if (wr_cnt + 32'd1 == n_words) begin
                     cap_en   <= 1'b0;
                     state    <= WDONE;
                  end else begin
                     bus.dma_hbusreq <= 1'b1;
                     state           <= WREQ;
                  end
               end
            end
            WDONE: begin
               isp_wdone <= 1'b1;
               state     <= WIDLE;
            end
            default: state <= WIDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_isp2wdma.sv
// tb_isp2wdma: randomized self-checking bench for isp2wdma. A behavioural AHB slave
// records every completed write; expected memory images come from the frame rules
// (first N captured pixels at base+4*i, overflow and error truncation).
module tb_isp2wdma;
   import isp2wdma_pkg::*;

   localparam int BITS    = 8;
   localparam int FIFO_AW = 4;
   localparam int DEPTH   = 16;

   logic            hclk = 1'b0;
   logic            hreset;
   logic [31:0]     isp_waddr, isp_hsize, isp_vsize, isp_start;
   logic            isp_wdone, isp_werr, isp_wovf;
   logic            out_href, out_vsync;
   logic [BITS-1:0] out_raw;

   isp2wdma_if bus ();

   isp2wdma #(.BITS(BITS), .FIFO_AW(FIFO_AW)) dut (
      .hclk      (hclk),
      .hreset    (hreset),
      .isp_waddr (isp_waddr),
      .isp_hsize (isp_hsize),
      .isp_vsize (isp_vsize),
      .isp_start (isp_start),
      .isp_wdone (isp_wdone),
      .isp_werr  (isp_werr),
      .isp_wovf  (isp_wovf),
      .bus       (bus),
      .out_href  (out_href),
      .out_vsync (out_vsync),
      .out_raw   (out_raw)
   );

   always #5 hclk = ~hclk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
   endtask

   // slave configuration and observations
   bit          grant_en = 0;
   int          ws_mode  = 0;
   int          err_at   = 0;
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];
   int          wdone_cnt, stab_err, proto_err, gviol, dp_cnt;

   initial begin
      bit          dp_pend = 0, dp_first = 0, hgrant_prev = 0, hr;
      logic [31:0] dp_addr = '0, dp_data0 = '0;
      logic [1:0]  htrans_prev = HTRANS_IDLE;
      int          dp_waits = 0;
      bus.hready_dma = 1'b1;
      bus.hresp_dma  = HRESP_OKAY;
      bus.hgrant     = 1'b0;
      bus.hrdata_dma = '0;
      forever begin
         @(negedge hclk);
         #1;
         if (hreset) begin
            dp_pend = 0; hgrant_prev = 0; htrans_prev = HTRANS_IDLE;
            bus.hready_dma = 1'b1; bus.hresp_dma = HRESP_OKAY; bus.hgrant = 1'b0;
            continue;
         end
         if (isp_wdone) wdone_cnt++;
         if (bus.dma_htrans == HTRANS_NONSEQ && htrans_prev != HTRANS_NONSEQ) begin
            if (!hgrant_prev) gviol++;
            if (!bus.dma_hwrite || bus.dma_hsize != HSIZE_WORD) proto_err++;
         end
         if (bus.dma_htrans != HTRANS_IDLE && bus.dma_htrans != HTRANS_NONSEQ) proto_err++;
         if (bus.dma_hburst != 3'b000 || bus.dma_hprot != 4'b0000 || bus.dma_hlock) proto_err++;
         if (dp_pend) begin
            if (dp_first) begin dp_data0 = bus.dma_hwdata; dp_first = 0; end
            else if (bus.dma_hwdata !== dp_data0) stab_err++;
         end
         hr = 1;
         if (dp_pend && dp_waits > 0) begin hr = 0; dp_waits--; end
         else if (!dp_pend && ws_mode == 2 && $urandom_range(0, 3) == 0) hr = 0;
         bus.hready_dma = hr;
         bus.hresp_dma  = (dp_pend && hr && (dp_cnt + 1 == err_at)) ? 2'b01 : HRESP_OKAY;
         htrans_prev = bus.dma_htrans;
         bus.hgrant  = grant_en;
         hgrant_prev = grant_en;
         if (hr) begin
            if (dp_pend) begin
               wr_addr_q.push_back(dp_addr);
               wr_data_q.push_back(bus.dma_hwdata);
               dp_cnt++;
               dp_pend = 0;
            end
            if (bus.dma_htrans == HTRANS_NONSEQ) begin
               dp_pend  = 1;
               dp_first = 1;
               dp_addr  = bus.dma_haddr;
               dp_waits = (ws_mode == 1) ? 2 : (ws_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            end
         end
      end
   end

   task automatic check_idle_outputs(input string nm);
      chk({nm, " ctl"}, 32'({bus.dma_htrans, bus.dma_hwrite, bus.dma_hsize, bus.dma_hbusreq,
                              isp_wdone, isp_werr, isp_wovf}), 32'h0);
      chk({nm, " haddr"}, bus.dma_haddr, 32'h0);
      chk({nm, " hwdata"}, bus.dma_hwdata, 32'h0);
   endtask

   // gdelay: 0 = grant from start, >0 = grant that many cycles after vsync,
   // <0 = grant only after all pixels are sent.
   task automatic run_frame(input string nm, input logic [31:0] base, input logic [31:0] hs,
                            input logic [31:0] vs, input int gdelay, input int wsm,
                            input int errat, input bit seq, input bit ovf);
      logic [31:0] n;
      logic [31:0] exp_q[$];
      int sent = 0, cyc = 0, to = 0, nexp;
      n = hs * vs;
      @(negedge hclk);
      wr_addr_q.delete(); wr_data_q.delete();
      wdone_cnt = 0; stab_err = 0; proto_err = 0; gviol = 0; dp_cnt = 0;
      ws_mode = wsm; err_at = errat; grant_en = (gdelay == 0);
      isp_waddr = base; isp_hsize = hs; isp_vsize = vs; isp_start = 32'h1;
      out_href = 0; out_vsync = 0;
      @(negedge hclk);
      isp_start = 32'hFFFF_FFFE;
      out_vsync = 1; out_href = 1; out_raw = 8'hEE;   // same cycle as vsync: not captured
      while (sent < int'(n) + 2 && cyc < 1000) begin
         @(negedge hclk);
         cyc++;
         out_vsync = (cyc == 3);
         if (gdelay > 0 && cyc >= gdelay) grant_en = 1;
         out_href = seq ? 1'b1 : ($urandom_range(0, 3) != 0);
         out_raw  = seq ? BITS'(16 + sent) : BITS'($urandom);
         if (out_href) begin
            if (sent < int'(n) && (!ovf || sent < DEPTH)) exp_q.push_back(32'(out_raw));
            sent++;
         end
      end
      @(negedge hclk);
      out_href = 0; out_vsync = 0; isp_start = 32'h0;
      while (gdelay > 0 && cyc < gdelay) begin @(negedge hclk); cyc++; end
      grant_en = 1;
      while (wdone_cnt == 0 && to < 3000) begin @(negedge hclk); to++; end
      chk({nm, " done"}, 32'(to < 3000), 32'h1);
      repeat (4) @(negedge hclk);
      if (errat > 0 && errat < exp_q.size()) exp_q = exp_q[0:errat-1];
      nexp = exp_q.size();
      chk({nm, " nwr"}, 32'(wr_addr_q.size()), 32'(nexp));
      for (int i = 0; i < nexp && i < wr_addr_q.size(); i++) begin
         chk($sformatf("%s addr%0d", nm, i), wr_addr_q[i], base + 32'(4 * i));
         chk($sformatf("%s data%0d", nm, i), wr_data_q[i], exp_q[i]);
      end
      chk({nm, " wdone"}, 32'(wdone_cnt), 32'h1);
      chk({nm, " werr"}, 32'(isp_werr), 32'(errat > 0));
      chk({nm, " wovf"}, 32'(isp_wovf), 32'(ovf));
      chk({nm, " grant"}, 32'(gviol), 32'h0);
      chk({nm, " hwdata_stable"}, 32'(stab_err), 32'h0);
      chk({nm, " proto"}, 32'(proto_err), 32'h0);
   endtask

   initial begin
      hreset = 1; isp_waddr = '0; isp_hsize = '0; isp_vsize = '0; isp_start = '0;
      out_href = 0; out_vsync = 0; out_raw = '0;
      repeat (3) @(negedge hclk);
      check_idle_outputs("reset");
      hreset = 0;
      repeat (2) @(negedge hclk);

      run_frame("basic",   32'h1000, 4, 2, 0, 0, 0, 1, 0);
      run_frame("waits",   32'h1000, 4, 2, 0, 1, 0, 1, 0);
      run_frame("nogrant", 32'h1000, 4, 2, 20, 0, 0, 1, 0);
      run_frame("ovf",     32'h1000, 24, 1, -1, 0, 0, 1, 1);
      run_frame("herr",    32'h2000, 4, 2, 0, 0, 3, 0, 0);
      for (int k = 0; k < 4; k++)
         run_frame($sformatf("rnd%0d", k), $urandom & 32'hFFFF_FFFC,
                   $urandom_range(1, 4), $urandom_range(1, 4), 0, 2, 0, 0, 0);
      run_frame("wrap",    32'hFFFF_FFF8, 3, 2, 0, 2, 0, 0, 0);

      // abort a frame with reset, then confirm the next frame has no stale words
      @(negedge hclk);
      grant_en = 1; ws_mode = 1; err_at = 0;
      isp_waddr = 32'h3000; isp_hsize = 8; isp_vsize = 1; isp_start = 32'h1;
      @(negedge hclk);
      isp_start = 0; out_vsync = 1;
      repeat (6) begin
         @(negedge hclk);
         out_vsync = 0; out_href = 1; out_raw = BITS'($urandom);
      end
      @(negedge hclk);
      hreset = 1; out_href = 0;
      repeat (2) @(negedge hclk);
      check_idle_outputs("midreset");
      hreset = 0;
      repeat (2) @(negedge hclk);
      run_frame("restart", 32'h3000, 3, 2, 0, 0, 0, 0, 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
